pic_inta_sequencer: RTL and testbench
=====================================

Name: pic_inta_sequencer

Overview:
Clocked interrupt-acknowledge and in-service controller for the 8259A PIC. It owns the 8-bit ISR and raises INT to the CPU when the priority resolver requests service. It runs the two-pulse INTA cycle: freeze resolver, set ISR, clear IRR, then drive the vector. It also executes OCW2 EOI/rotate commands and AEOI, and feeds cleared-ISR indices back to the resolver for rotation.

Parameters:
SPURIOUS_INDEX, 3'd7, index used for the vector when no IRR bit is pending at the first INTA.
NUM_IRQ, 8, number of request lines; fixed at 8, width of the ISR and IRR buses.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
int_request  input  1  resolver wants service (level)
resolved_index  input  3  highest-priority pending IR from resolver
priority_base  input  3  resolver zero-level priority bit
irr_reg  input  8  current IRR contents
inta_n  input  1  CPU acknowledge, active low, already synchronised to clk
vector_base  input  5  ICW2 T7..T3
aeoi  input  1  ICW4 auto-EOI enable
eoi_valid  input  1  one-cycle strobe: OCW2 written
eoi_cmd  input  3  OCW2 D7..D5
eoi_level  input  3  OCW2 L2..L0
int_out  output  1  INT pin to CPU
int_request_ack  output  1  one-cycle pulse to resolver
freeze  output  1  holds resolver inputs during INTA cycle
isr_reg  output  8  in-service register
irr_clear_valid  output  1  one-cycle pulse: clear IRR bit
irr_clear_index  output  3  IRR bit to clear
isr_cleared_valid  output  1  one-cycle pulse: an ISR bit was cleared
isr_cleared_index  output  3  index of the cleared ISR bit (resolver resetedISR_index)
data_out  output  8  vector byte
data_oe  output  1  data bus drive enable

Behaviour:
- Reset: state IDLE, int_out=0, freeze=0, isr_reg=0, data_out=0, data_oe=0, all pulses 0, indices 0, cur_idx=0, inta_prev=1. A reset in any state aborts the cycle with no ISR/IRR side effects.
- Edge detect: fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n; inta_prev is registered every cycle.
- IDLE: if int_request=1 -> WAIT1. Next cycle int_out=1, and int_request_ack pulses for 1 cycle. INTA edges in IDLE are ignored; data_oe stays 0.
- WAIT1: int_out held at 1. On fall -> ACK1, and at the next edge: int_out=0, freeze=1.
  - If irr_reg!=0: cur_idx=resolved_index, isr_reg[cur_idx] set, irr_clear_valid pulsed with irr_clear_index=cur_idx.
  - If irr_reg==0 (spurious): cur_idx=SPURIOUS_INDEX, no ISR set, no IRR clear.
- ACK1: on rise -> GAP.
- GAP: on fall -> ACK2. data_out={vector_base,cur_idx} and data_oe=1 from the next cycle.
- ACK2: data_oe held while inta_n low. On rise -> IDLE, and at the next edge:
  - data_oe=0 and freeze=0.
  - If aeoi=1 and the cycle was not spurious: isr_reg[cur_idx] cleared, isr_cleared_valid pulsed with index cur_idx.
- Latency: int_request to int_out is 1 cycle. INTA fall to ISR set, or to data_oe, is 1 cycle.
- EOI (any state, when eoi_valid=1):
  - 001 or 101 (non-specific): clear the first set bit of isr_reg scanning (priority_base+k) mod 8 for k=0..7. If isr_reg==0: no clear, no pulse.
  - 011 or 111 (specific): clear isr_reg[eoi_level]. The pulse fires only if that bit was set.
  - Other codes: no action.
  - Any clear pulses isr_cleared_valid with the cleared index, 1 cycle after eoi_valid.
- Simultaneous events:
  - ISR set (ACK1 entry) and EOI in the same cycle: the EOI scan uses the pre-set isr_reg.
  - If the EOI targets the bit being set, the set wins.
  - AEOI clear and EOI clear in the same cycle: AEOI is reported; the EOI clear still applies, but its pulse is dropped.
- int_request dropping during WAIT1 does not deassert int_out. The spurious path covers that case.

Test Plan:
- Normal cycle: reset, int_request=1, resolved_index=3, irr_reg=8'h08, vector_base=5'h01, two INTA pulses -> int_out=1 after 1 clk; isr_reg=8'h08; irr_clear_index=3; data_out=8'h0B with data_oe=1 during 2nd INTA; int_out=0 after 1st INTA.
- AEOI: same stimulus with aeoi=1 -> after 2nd INTA rise, isr_reg=8'h00 and isr_cleared_valid with index 3.
- Non-specific EOI rotation: isr_reg=8'h24, priority_base=3, eoi_cmd=001 -> bit 5 cleared, isr_reg=8'h04, isr_cleared_index=5; repeat with priority_base=0 from 8'h24 -> bit 2 cleared.
- Specific EOI on a clear bit: isr_reg=8'h01, eoi_cmd=011, eoi_level=4 -> isr_reg unchanged, no pulse.
- Spurious: int_request then irr_reg=0 at 1st INTA, vector_base=5'h02 -> no ISR set, no irr_clear_valid, data_out=8'h17.
- Reset mid-cycle: reset asserted in GAP -> next cycle isr_reg=0, freeze=0, data_oe=0, state IDLE; a later 2nd INTA pulse produces no drive.

Source files
------------

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
// Interrupt-acknowledge and in-service controller for an 8259A-style PIC.
// Owns the in-service register, raises INT toward the CPU when the priority
// resolver asks for service, walks the two-pulse INTA handshake (freeze the
// resolver, set ISR, clear IRR, then drive the vector byte) and executes
// OCW2 EOI commands and auto-EOI, reporting every cleared ISR bit back to the
// resolver so it can rotate priorities.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   int_request           resolver wants service (level)
//   resolved_index        highest-priority pending IR from the resolver
//   priority_base         resolver zero-level priority bit (EOI scan start)
//   irr_reg               current IRR contents
//   inta_n                CPU acknowledge, active low, already synchronised
//   vector_base           ICW2 T7..T3
//   aeoi                  ICW4 auto-EOI enable
//   eoi_valid/cmd/level   OCW2 write strobe, D7..D5 and L2..L0
//   int_out               INT pin to the CPU
//   int_request_ack       one-cycle pulse to the resolver
//   freeze                holds resolver inputs during the INTA cycle
//   isr_reg               in-service register
//   irr_clear_valid/index one-cycle request to clear an IRR bit
//   isr_cleared_valid/index one-cycle report of a cleared ISR bit
//   data_out, data_oe     vector byte and data bus drive enable
module pic_inta_sequencer #(
    parameter logic [2:0] SPURIOUS_INDEX = 3'd7,
    parameter int         NUM_IRQ        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               int_request,
    input  logic [2:0]         resolved_index,
    input  logic [2:0]         priority_base,
    input  logic [NUM_IRQ-1:0] irr_reg,
    input  logic               inta_n,
    input  logic [4:0]         vector_base,
    input  logic               aeoi,
    input  logic               eoi_valid,
    input  logic [2:0]         eoi_cmd,
    input  logic [2:0]         eoi_level,
    output logic               int_out,
    output logic               int_request_ack,
    output logic               freeze,
    output logic [NUM_IRQ-1:0] isr_reg,
    output logic               irr_clear_valid,
    output logic [2:0]         irr_clear_index,
    output logic               isr_cleared_valid,
    output logic [2:0]         isr_cleared_index,
    output logic [7:0]         data_out,
    output logic               data_oe
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT1 = 3'd1;
    localparam logic [2:0] ST_ACK1  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_ACK2  = 3'd4;

    logic [2:0]         state_r;
    logic               inta_prev_r;
    logic [2:0]         cur_idx_r;
    logic               spurious_r;

    logic               fall_s;
    logic               rise_s;
    logic               set_hit_s;
    logic               aeoi_hit_s;
    logic               eoi_hit_s;
    logic [2:0]         eoi_idx_s;
    logic [3:0]         scan_s;
    logic [NUM_IRQ-1:0] set_mask_s;
    logic [NUM_IRQ-1:0] aeoi_mask_s;
    logic [NUM_IRQ-1:0] eoi_mask_s;

    // First set bit of 'bits' scanning upward from 'base' with wrap-around.
    // Returns {found, index}.
    function automatic logic [3:0] scan_first(input logic [7:0] bits,
                                              input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 0; k < 8; k++) begin
            idx = base + k[2:0];
            if (!res[3] && bits[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign fall_s     = inta_prev_r & ~inta_n;
    assign rise_s     = ~inta_prev_r & inta_n;
    assign set_hit_s  = (state_r == ST_WAIT1) && fall_s && (irr_reg != 8'h00);
    assign aeoi_hit_s = (state_r == ST_ACK2) && rise_s && aeoi && !spurious_r;
    assign scan_s     = scan_first(isr_reg, priority_base);

    // OCW2 decode: which ISR bit (if any) an EOI write clears this cycle.
    // The scan sees the ISR before any same-cycle set.
    always_comb begin
        eoi_hit_s = 1'b0;
        eoi_idx_s = 3'd0;
        if (eoi_valid) begin
            case (eoi_cmd)
                3'b001, 3'b101: begin
                    eoi_hit_s = scan_s[3];
                    eoi_idx_s = scan_s[2:0];
                end
                3'b011, 3'b111: begin
                    eoi_hit_s = isr_reg[eoi_level];
                    eoi_idx_s = eoi_level;
                end
                default: begin
                    eoi_hit_s = 1'b0;
                    eoi_idx_s = 3'd0;
                end
            endcase
        end else begin
            eoi_hit_s = 1'b0;
            eoi_idx_s = 3'd0;
        end
    end

    // Per-bit set/clear masks applied to the ISR.
    always_comb begin
        set_mask_s  = set_hit_s  ? (8'd1 << resolved_index) : 8'd0;
        aeoi_mask_s = aeoi_hit_s ? (8'd1 << cur_idx_r)      : 8'd0;
        eoi_mask_s  = eoi_hit_s  ? (8'd1 << eoi_idx_s)      : 8'd0;
    end

    // ISR update and cleared-bit report; a set overrides a clear of the same
    // bit, and an AEOI report takes the pulse over a simultaneous EOI.
    always_ff @(posedge clk) begin
        if (reset) begin
            isr_reg           <= 8'd0;
            isr_cleared_valid <= 1'b0;
            isr_cleared_index <= 3'd0;
        end else begin
            isr_reg <= (isr_reg & ~eoi_mask_s & ~aeoi_mask_s) | set_mask_s;
            if (aeoi_hit_s) begin
                isr_cleared_valid <= 1'b1;
                isr_cleared_index <= cur_idx_r;
            end else if (eoi_hit_s) begin
                isr_cleared_valid <= 1'b1;
                isr_cleared_index <= eoi_idx_s;
            end else begin
                isr_cleared_valid <= 1'b0;
                isr_cleared_index <= isr_cleared_index;
            end
        end
    end

    // INTA handshake sequencer and its registered bus/handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            inta_prev_r     <= 1'b1;
            cur_idx_r       <= 3'd0;
            spurious_r      <= 1'b0;
            int_out         <= 1'b0;
            int_request_ack <= 1'b0;
            freeze          <= 1'b0;
            irr_clear_valid <= 1'b0;
            irr_clear_index <= 3'd0;
            data_out        <= 8'd0;
            data_oe         <= 1'b0;
        end else begin
            inta_prev_r     <= inta_n;
            int_request_ack <= 1'b0;
            irr_clear_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (int_request) begin
                        state_r         <= ST_WAIT1;
                        int_out         <= 1'b1;
                        int_request_ack <= 1'b1;
                    end
                end
                ST_WAIT1: begin
                    if (fall_s) begin
                        state_r <= ST_ACK1;
                        int_out <= 1'b0;
                        freeze  <= 1'b1;
                        if (irr_reg != 8'h00) begin
                            cur_idx_r       <= resolved_index;
                            spurious_r      <= 1'b0;
                            irr_clear_valid <= 1'b1;
                            irr_clear_index <= resolved_index;
                        end else begin
                            cur_idx_r  <= SPURIOUS_INDEX;
                            spurious_r <= 1'b1;
                        end
                    end
                end
                ST_ACK1: begin
                    if (rise_s) begin
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (fall_s) begin
                        state_r  <= ST_ACK2;
                        data_out <= {vector_base, cur_idx_r};
                        data_oe  <= 1'b1;
                    end
                end
                ST_ACK2: begin
                    if (rise_s) begin
                        state_r <= ST_IDLE;
                        data_oe <= 1'b0;
                        freeze  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    int_out <= 1'b0;
                    freeze  <= 1'b0;
                    data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed scoreboard bench for pic_inta_sequencer. Stimulus pushes the
// expected output events; a negedge monitor pops and compares them.
module tb_pic_inta_sequencer;

    logic       clk;
    logic       reset;
    logic       int_request;
    logic [2:0] resolved_index;
    logic [2:0] priority_base;
    logic [7:0] irr_reg;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       int_out;
    logic       int_request_ack;
    logic       freeze;
    logic [7:0] isr_reg;
    logic       irr_clear_valid;
    logic [2:0] irr_clear_index;
    logic       isr_cleared_valid;
    logic [2:0] isr_cleared_index;
    logic [7:0] data_out;
    logic       data_oe;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] value;
    } exp_t;

    localparam logic [1:0] K_ACK = 2'd0;
    localparam logic [1:0] K_IRR = 2'd1;
    localparam logic [1:0] K_ISR = 2'd2;
    localparam logic [1:0] K_VEC = 2'd3;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    logic oe_prev;

    pic_inta_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .int_request       (int_request),
        .resolved_index    (resolved_index),
        .priority_base     (priority_base),
        .irr_reg           (irr_reg),
        .inta_n            (inta_n),
        .vector_base       (vector_base),
        .aeoi              (aeoi),
        .eoi_valid         (eoi_valid),
        .eoi_cmd           (eoi_cmd),
        .eoi_level         (eoi_level),
        .int_out           (int_out),
        .int_request_ack   (int_request_ack),
        .freeze            (freeze),
        .isr_reg           (isr_reg),
        .irr_clear_valid   (irr_clear_valid),
        .irr_clear_index   (irr_clear_index),
        .isr_cleared_valid (isr_cleared_valid),
        .isr_cleared_index (isr_cleared_index),
        .data_out          (data_out),
        .data_oe           (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic check_evt(input logic [1:0] kind, input logic [7:0] value);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d actual=%02h required=none", kind, value);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.value !== value) begin
                failures++;
                $display("FAIL event actual=kind%0d/%02h required=kind%0d/%02h",
                         kind, value, e.kind, e.value);
            end
        end
    endtask

    // Monitor: every pulse / data_oe rise consumes one scoreboard entry.
    always @(negedge clk) begin
        if (int_request_ack)   check_evt(K_ACK, {7'd0, int_out});
        if (irr_clear_valid)   check_evt(K_IRR, {5'd0, irr_clear_index});
        if (isr_cleared_valid) check_evt(K_ISR, {5'd0, isr_cleared_index});
        if (data_oe === 1'b1 && oe_prev !== 1'b1) check_evt(K_VEC, data_out);
        oe_prev = data_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Full two-pulse INTA cycle with hand-computed expectations.
    task automatic run_cycle(input logic [2:0] idx, input logic [7:0] irr,
                             input logic [4:0] vb, input logic ae,
                             input logic [7:0] exp_vec,
                             input logic [7:0] isr_ack1, input logic [7:0] isr_end,
                             input logic exp_irr_clr, input logic exp_aeoi_clr);
        resolved_index = idx;
        irr_reg        = irr;
        vector_base    = vb;
        aeoi           = ae;
        push(K_ACK, 8'd1);
        int_request = 1'b1;
        tick();
        chk("int_out_raise", {7'd0, int_out}, 8'd1);
        int_request = 1'b0;
        tick();
        chk("int_out_hold", {7'd0, int_out}, 8'd1);
        if (exp_irr_clr) push(K_IRR, {5'd0, idx});
        inta_n = 1'b0;
        tick();
        chk("int_out_after_inta1", {7'd0, int_out}, 8'd0);
        chk("freeze_ack1", {7'd0, freeze}, 8'd1);
        chk("isr_ack1", isr_reg, isr_ack1);
        inta_n = 1'b1;
        tick();
        tick();
        push(K_VEC, exp_vec);
        inta_n = 1'b0;
        tick();
        chk("data_oe_ack2", {7'd0, data_oe}, 8'd1);
        chk("data_out_ack2", data_out, exp_vec);
        tick();
        chk("data_oe_hold", {7'd0, data_oe}, 8'd1);
        if (exp_aeoi_clr) push(K_ISR, {5'd0, idx});
        inta_n = 1'b1;
        tick();
        chk("data_oe_end", {7'd0, data_oe}, 8'd0);
        chk("freeze_end", {7'd0, freeze}, 8'd0);
        chk("isr_end", isr_reg, isr_end);
        aeoi = 1'b0;
        tick();
    endtask

    task automatic do_eoi(input logic [2:0] cmd, input logic [2:0] lvl,
                          input logic [2:0] base, input logic exp_pulse,
                          input logic [2:0] exp_idx, input logic [7:0] exp_isr);
        if (exp_pulse) push(K_ISR, {5'd0, exp_idx});
        eoi_cmd       = cmd;
        eoi_level     = lvl;
        priority_base = base;
        eoi_valid     = 1'b1;
        tick();
        eoi_valid = 1'b0;
        chk("isr_after_eoi", isr_reg, exp_isr);
        tick();
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        oe_prev        = 1'b0;
        reset          = 1'b1;
        int_request    = 1'b0;
        resolved_index = 3'd0;
        priority_base  = 3'd0;
        irr_reg        = 8'h00;
        inta_n         = 1'b1;
        vector_base    = 5'd0;
        aeoi           = 1'b0;
        eoi_valid      = 1'b0;
        eoi_cmd        = 3'd0;
        eoi_level      = 3'd0;
        repeat (2) tick();
        chk("rst_int_out", {7'd0, int_out}, 8'd0);
        chk("rst_freeze", {7'd0, freeze}, 8'd0);
        chk("rst_isr", isr_reg, 8'h00);
        chk("rst_data_oe", {7'd0, data_oe}, 8'd0);
        chk("rst_data_out", data_out, 8'h00);
        reset = 1'b0;
        tick();

        // INTA edges while idle must not drive the bus.
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        chk("idle_inta_no_oe", {7'd0, data_oe}, 8'd0);

        // Normal cycle, then specific EOI on level 3.
        run_cycle(3'd3, 8'h08, 5'h01, 1'b0, 8'h0B, 8'h08, 8'h08, 1'b1, 1'b0);
        do_eoi(3'b011, 3'd3, 3'd0, 1'b1, 3'd3, 8'h00);

        // Auto-EOI clears the bit at the second INTA rise.
        run_cycle(3'd3, 8'h08, 5'h01, 1'b1, 8'h0B, 8'h08, 8'h00, 1'b1, 1'b1);

        // Build ISR = 8'h24 and exercise non-specific EOI rotation.
        run_cycle(3'd2, 8'h04, 5'h01, 1'b0, 8'h0A, 8'h04, 8'h04, 1'b1, 1'b0);
        run_cycle(3'd5, 8'h20, 5'h01, 1'b0, 8'h0D, 8'h24, 8'h24, 1'b1, 1'b0);
        do_eoi(3'b001, 3'd0, 3'd3, 1'b1, 3'd5, 8'h04);
        run_cycle(3'd5, 8'h20, 5'h01, 1'b0, 8'h0D, 8'h24, 8'h24, 1'b1, 1'b0);
        do_eoi(3'b101, 3'd0, 3'd0, 1'b1, 3'd2, 8'h20);
        do_eoi(3'b010, 3'd5, 3'd0, 1'b0, 3'd0, 8'h20);
        do_eoi(3'b111, 3'd5, 3'd0, 1'b1, 3'd5, 8'h00);
        do_eoi(3'b001, 3'd0, 3'd4, 1'b0, 3'd0, 8'h00);

        // Specific EOI on a clear bit: no change, no pulse.
        run_cycle(3'd0, 8'h01, 5'h01, 1'b0, 8'h08, 8'h01, 8'h01, 1'b1, 1'b0);
        do_eoi(3'b011, 3'd4, 3'd0, 1'b0, 3'd0, 8'h01);
        do_eoi(3'b111, 3'd0, 3'd0, 1'b1, 3'd0, 8'h00);

        // Spurious: nothing pending at first INTA, vector uses index 7.
        run_cycle(3'd4, 8'h00, 5'h02, 1'b1, 8'h17, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset asserted in GAP aborts the cycle.
        resolved_index = 3'd1;
        irr_reg        = 8'h02;
        vector_base    = 5'h03;
        push(K_ACK, 8'd1);
        int_request = 1'b1;
        tick();
        int_request = 1'b0;
        push(K_IRR, 8'd1);
        inta_n = 1'b0;
        tick();
        chk("mid_isr_set", isr_reg, 8'h02);
        inta_n = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_isr", isr_reg, 8'h00);
        chk("mid_rst_freeze", {7'd0, freeze}, 8'd0);
        chk("mid_rst_data_oe", {7'd0, data_oe}, 8'd0);
        chk("mid_rst_int_out", {7'd0, int_out}, 8'd0);
        inta_n = 1'b0;
        tick();
        tick();
        chk("mid_rst_no_drive", {7'd0, data_oe}, 8'd0);
        inta_n = 1'b1;
        tick();
        chk("mid_rst_idle_int", {7'd0, int_out}, 8'd0);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
